// File: rtl/i2c_txn_arbiter_if.sv
// rtl/i2c_txn_arbiter_if.sv - requester and front-end signal bundle for i2c_txn_arbiter
//
// Purpose: carries the NUM_REQ requester handshakes and the I2C front-end
// register-block connections as one bundle.
//   slave  : the arbiter view (consumes requests and front-end status,
//            drives accepts, responses, front-end fields/strobes and busy)
//   master : the environment view (requesters plus the front-end)
// Signals:
//   req_valid/req_ready/req_rnw  per-requester request handshake and direction
//   req_dev_addr/req_reg_num/req_len/req_wdata  packed per-requester fields (slice k)
//   rsp_valid/rsp_data/rsp_fault per-requester completion pulse, shared data/fault
//   fe_*                          front-end register inputs, strobes and status
//   busy                          transaction in flight
interface i2c_txn_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_rnw;
    logic [7*NUM_REQ-1:0]  req_dev_addr;
    logic [8*NUM_REQ-1:0]  req_reg_num;
    logic [3*NUM_REQ-1:0]  req_len;
    logic [32*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_data;
    logic [1:0]            rsp_fault;
    logic [6:0]            fe_dev_addr;
    logic [7:0]            fe_reg_num;
    logic [31:0]           fe_tx_data;
    logic [2:0]            fe_len;
    logic                  fe_read_start;
    logic                  fe_write_start;
    logic                  fe_idle;
    logic                  fe_fault;
    logic [31:0]           fe_rx_data;
    logic                  busy;

    modport slave (
        input  req_valid, req_rnw, req_dev_addr, req_reg_num, req_len, req_wdata,
        input  fe_idle, fe_fault, fe_rx_data,
        output req_ready, rsp_valid, rsp_data, rsp_fault,
        output fe_dev_addr, fe_reg_num, fe_tx_data, fe_len, fe_read_start, fe_write_start,
        output busy
    );

    modport master (
        output req_valid, req_rnw, req_dev_addr, req_reg_num, req_len, req_wdata,
        output fe_idle, fe_fault, fe_rx_data,
        input  req_ready, rsp_valid, rsp_data, rsp_fault,
        input  fe_dev_addr, fe_reg_num, fe_tx_data, fe_len, fe_read_start, fe_write_start,
        input  busy
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin sharing of one I2C front-end between NUM_REQ requesters
//
// Purpose: grants one pending requester at a time (round-robin), launches its
// transaction on the front-end, waits for the front-end to go idle (or time out)
// and returns rx data and a fault code to the granted requester.
// Ports:
//   clk     clock
//   resetn  asynchronous active-low reset; aborts any transaction silently
//   bus     i2c_txn_arbiter_if.slave - requester handshakes, front-end fields,
//           strobes, status and busy
// Fault codes: 0 ok, 1 device fault, 2 timeout, 3 bad length.
module i2c_txn_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic             clk,
    input  logic             resetn,
    i2c_txn_arbiter_if.slave bus
);
    localparam int IW      = $clog2(NUM_REQ);
    localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] LAST_REQ     = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, gnt_q, pick, idx;
    logic            found, grant, bad_len, active;
    logic            rnw_q;
    logic [6:0]      dev_q;
    logic [7:0]      reg_q;
    logic [2:0]      len_q, sel_len;
    logic [31:0]     wdata_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic [1:0]      rsp_fault_q, rsp_fault_d;

    // First pending requester at or after the round-robin pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((int'(rr_q) + i) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // resetn gates the accept so no req_ready can pulse while held in reset.
    assign grant   = resetn && (state_q == S_IDLE) && bus.fe_idle && found;
    assign sel_len = bus.req_len[3*int'(pick) +: 3];
    assign bad_len = (sel_len == 3'd0) || (sel_len > 3'd4);
    assign active  = (state_q == S_ISSUE) || (state_q == S_SETTLE) || (state_q == S_WAIT);

    // State register plus the request latch, timeout counter and response hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            gnt_q       <= '0;
            rnw_q       <= 1'b0;
            dev_q       <= '0;
            reg_q       <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_fault_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
            if (grant) begin
                gnt_q   <= pick;
                rr_q    <= (pick == LAST_REQ) ? '0 : pick + 1'b1;
                rnw_q   <= bus.req_rnw[pick];
                dev_q   <= bus.req_dev_addr[7*int'(pick) +: 7];
                reg_q   <= bus.req_reg_num[8*int'(pick) +: 8];
                len_q   <= sel_len;
                wdata_q <= bus.req_wdata[32*int'(pick) +: 32];
                cnt_q   <= '0;
            end else if (active) begin
                // cnt_q equals the number of cycles since the start strobe.
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Next state and the response captured on entry to RESP.
    always_comb begin
        state_d     = state_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    if (bad_len) begin
                        state_d     = S_RESP;
                        rsp_data_d  = '0;
                        rsp_fault_d = 2'd3;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE:  state_d = (SETTLE_CYC == 0) ? S_WAIT : S_SETTLE;
            S_SETTLE: if (cnt_q >= SETTLE_LAST) state_d = S_WAIT;
            S_WAIT: begin
                // A completion seen in the same cycle as the deadline wins.
                if (bus.fe_idle) begin
                    state_d     = S_RESP;
                    rsp_data_d  = rnw_q ? bus.fe_rx_data : 32'd0;
                    rsp_fault_d = bus.fe_fault ? 2'd1 : 2'd0;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    state_d     = S_RESP;
                    rsp_data_d  = '0;
                    rsp_fault_d = 2'd2;
                end
            end
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decode from state so reset clears them without waiting for a clock.
    always_comb begin
        bus.req_ready = '0;
        if (grant) bus.req_ready[pick] = 1'b1;
        bus.rsp_valid = '0;
        if (state_q == S_RESP) bus.rsp_valid[gnt_q] = 1'b1;
        bus.rsp_data       = (state_q == S_RESP) ? rsp_data_q  : 32'd0;
        bus.rsp_fault      = (state_q == S_RESP) ? rsp_fault_q : 2'd0;
        bus.fe_dev_addr    = active ? dev_q   : 7'd0;
        bus.fe_reg_num     = active ? reg_q   : 8'd0;
        bus.fe_tx_data     = active ? wdata_q : 32'd0;
        bus.fe_len         = active ? len_q   : 3'd0;
        bus.fe_read_start  = (state_q == S_ISSUE) &&  rnw_q;
        bus.fe_write_start = (state_q == S_ISSUE) && !rnw_q;
        bus.busy           = (state_q != S_IDLE);
    end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - self-checking bench for i2c_txn_arbiter
module tb_i2c_txn_arbiter;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    i2c_txn_arbiter_if #(.NUM_REQ(NR)) bus ();

    i2c_txn_arbiter #(
        .NUM_REQ(NR), .SETTLE_CYC(2), .TIMEOUT_CYC(50)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    typedef struct {
        int          k;
        logic        rnw;
        logic [6:0]  dev;
        logic [7:0]  regn;
        logic [2:0]  len;
        logic [31:0] wdata;
        logic [31:0] rx;
        logic        fin;
        int          delay;      // cycles after strobe before fe_idle returns
        logic [1:0]  exp_strobe; // {read, write}
        logic [31:0] exp_data;
        logic [1:0]  exp_fault;
        int          exp_lat;    // strobe-to-rsp cycles, 0 = not checked
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int k, input logic rnw, input logic [6:0] dev,
                           input logic [7:0] regn, input logic [2:0] len, input logic [31:0] wd);
        bus.req_rnw[k]              = rnw;
        bus.req_dev_addr[7*k +: 7]  = dev;
        bus.req_reg_num[8*k +: 8]   = regn;
        bus.req_len[3*k +: 3]       = len;
        bus.req_wdata[32*k +: 32]   = wd;
    endtask

    task automatic clear_req();
        bus.req_valid    = '0;
        bus.req_rnw      = '0;
        bus.req_dev_addr = '0;
        bus.req_reg_num  = '0;
        bus.req_len      = '0;
        bus.req_wdata    = '0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int n;
        int strobes;
        @(negedge clk);
        bus.fe_idle = 1'b1; bus.fe_fault = 1'b0; bus.fe_rx_data = '0;
        set_req(v.k, v.rnw, v.dev, v.regn, v.len, v.wdata);
        bus.req_valid[v.k] = 1'b1;
        #1;
        n = 0;
        while (bus.req_ready == '0 && n < 10) begin @(negedge clk); #1; n++; end
        chk($sformatf("v%0d ready", id), bus.req_ready, 32'(1) << v.k);
        // Drop the request and scramble its fields: the grant must have latched them.
        @(negedge clk);
        clear_req();
        #1;
        chk($sformatf("v%0d strobe", id), {bus.fe_read_start, bus.fe_write_start}, v.exp_strobe);
        if (v.exp_strobe != 2'b00) begin
            chk($sformatf("v%0d fe_dev", id), bus.fe_dev_addr, v.dev);
            chk($sformatf("v%0d fe_reg", id), bus.fe_reg_num, v.regn);
            chk($sformatf("v%0d fe_len", id), bus.fe_len, v.len);
            chk($sformatf("v%0d fe_tx", id), bus.fe_tx_data, v.wdata);
            chk($sformatf("v%0d busy", id), bus.busy, 1);
            bus.fe_idle = 1'b0;
            n = 0;
            strobes = 0;
            while (bus.rsp_valid == '0 && n < 200) begin
                if (n == v.delay) begin
                    bus.fe_idle = 1'b1; bus.fe_fault = v.fin; bus.fe_rx_data = v.rx;
                end
                @(negedge clk); #1; n++;
                strobes += int'(bus.fe_read_start) + int'(bus.fe_write_start);
            end
            chk($sformatf("v%0d extra strobes", id), strobes, 0);
            if (v.exp_lat != 0) chk($sformatf("v%0d latency", id), n, v.exp_lat);
        end
        chk($sformatf("v%0d rsp_valid", id), bus.rsp_valid, 32'(1) << v.k);
        chk($sformatf("v%0d rsp_data", id), bus.rsp_data, v.exp_data);
        chk($sformatf("v%0d rsp_fault", id), bus.rsp_fault, v.exp_fault);
        @(negedge clk); #1;
        chk($sformatf("v%0d rsp clear", id), {bus.rsp_valid, bus.rsp_fault, bus.rsp_data}, 0);
        bus.fe_idle = 1'b1; bus.fe_fault = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   exp_order[5];
        int   n, seen, gcount, last_t, strobes, viol;

        vecs[0] = '{0, 1'b1, 7'h50, 8'h10, 3'd2, 32'h0,        32'h0000_1234, 1'b0, 20,   2'b10, 32'h0000_1234, 2'd0, 0};
        vecs[1] = '{1, 1'b0, 7'h22, 8'h05, 3'd4, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, 5,    2'b01, 32'h0,         2'd1, 0};
        vecs[2] = '{2, 1'b1, 7'h11, 8'h01, 3'd0, 32'h0,        32'h0,         1'b0, 0,    2'b00, 32'h0,         2'd3, 0};
        vecs[3] = '{3, 1'b0, 7'h12, 8'h02, 3'd5, 32'h1111,     32'h0,         1'b0, 0,    2'b00, 32'h0,         2'd3, 0};
        vecs[4] = '{0, 1'b1, 7'h33, 8'h44, 3'd1, 32'h0,        32'h0000_CAFE, 1'b0, 1000, 2'b10, 32'h0,         2'd2, 50};
        vecs[5] = '{1, 1'b1, 7'h48, 8'h9A, 3'd4, 32'h5,        32'hA5A5_5A5A, 1'b0, 0,    2'b10, 32'hA5A5_5A5A, 2'd0, 4};
        vecs[6] = '{2, 1'b1, 7'h7F, 8'hFF, 3'd3, 32'h0,        32'h0000_0077, 1'b1, 7,    2'b10, 32'h0000_0077, 2'd1, 0};
        exp_order = '{0, 1, 2, 3, 0};

        resetn = 1'b0;
        clear_req();
        bus.fe_idle = 1'b1; bus.fe_fault = 1'b0; bus.fe_rx_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset busy", bus.busy, 0);
        chk("reset rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_fault}, 0);
        chk("reset fe", {bus.fe_dev_addr, bus.fe_reg_num, bus.fe_len, bus.fe_read_start, bus.fe_write_start}, 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset during WAIT: silent abort.
        @(negedge clk);
        set_req(1, 1'b1, 7'h2A, 8'h33, 3'd2, 32'h0);
        bus.req_valid = 4'b0010;
        #1;
        n = 0;
        while (bus.req_ready == '0 && n < 10) begin @(negedge clk); #1; n++; end
        chk("rst ready", bus.req_ready, 4'b0010);
        @(negedge clk); #1;
        chk("rst strobe", bus.fe_read_start, 1);
        bus.fe_idle = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("rst in wait busy", bus.busy, 1);
        resetn = 1'b0;
        #1;
        chk("rst async busy", bus.busy, 0);
        chk("rst async fe", {bus.fe_dev_addr, bus.fe_reg_num, bus.fe_len, bus.fe_tx_data}, 0);
        chk("rst async rsp", bus.rsp_valid, 0);
        chk("rst async ready", bus.req_ready, 0);
        bus.fe_idle = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (bus.rsp_valid != '0 || bus.req_ready != '0) seen++;
        end
        chk("rst no rsp", seen, 0);

        // Post-reset round-robin with all requesters pending.
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < NR; k++) set_req(k, 1'b1, 7'(k + 1), 8'(k), 3'd1, 32'h0);
        bus.req_valid = 4'hF;
        #1;
        gcount = 0; last_t = 0; strobes = 0; viol = 0;
        for (int t = 0; t < 80 && gcount < 5; t++) begin
            if (t > 0) begin @(negedge clk); #1; end
            if (bus.req_ready != '0) begin
                chk($sformatf("rr grant %0d", gcount), bus.req_ready, 32'(1) << exp_order[gcount]);
                if (gcount > 0) begin
                    chk($sformatf("rr spacing %0d", gcount), t - last_t, 6);
                    chk($sformatf("rr strobes %0d", gcount), strobes, 1);
                end
                strobes = 0;
                last_t = t;
                gcount++;
            end
            if (bus.fe_read_start || bus.fe_write_start) strobes++;
            if ((bus.fe_read_start || bus.fe_write_start) && bus.rsp_valid != '0) viol++;
            if ($countones(bus.rsp_valid) > 1 || $countones(bus.req_ready) > 1) viol++;
        end
        chk("rr grants", gcount, 5);
        chk("rr exclusivity", viol, 0);
        @(negedge clk);
        clear_req();
        repeat (12) @(negedge clk);
        #1;
        chk("final idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
